// File: rtl/upcoin_nonce_scheduler.sv
// upcoin_nonce_scheduler: autonomous proof-of-work nonce sequencer for a single SHA-256 core.
// For each nonce it feeds the two padded blocks of an 80-byte header through the core,
// waits out each compression and compares the digest against a 256-bit target.
// Optional macro UPCOIN_DOUBLE_HASH_EN adds a second SHA-256 pass over the first digest.
module upcoin_nonce_scheduler #(
    parameter int unsigned BLOCK_CYCLES = 68
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         abort,
    input  logic [639:0] header,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  result_nonce,
    output logic [255:0] result_hash,
    output logic         core_message_load,
    output logic         core_block_load,
    output logic [511:0] core_block,
    input  logic         core_done,
    input  logic [255:0] core_hash
);

    localparam int unsigned CntW = (BLOCK_CYCLES > 1) ? $clog2(BLOCK_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BLOCK_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StKick0,
        StRun0,
        StKick1,
        StRun1,
        StFinish,
        StCheck
`ifdef UPCOIN_DOUBLE_HASH_EN
        ,
        StLoad2,
        StKick2,
        StRun2,
        StFinish2
`endif
    } state_e;

    state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Search context latched on an accepted start; the nonce field of the header is not kept.
    logic [639:32] hdr_q;
    logic [255:0]  target_q;
    logic [31:0]   nonce_q;
    logic [31:0]   nonce_end_q;
    logic          found_q;
    logic          exhausted_q;
    logic [31:0]   result_nonce_q;
    logic [255:0]  result_hash_q;

    logic [511:0] block0;
    logic [511:0] block1;
    logic         hit;
    logic         last_nonce;
    logic         accept;

    // Header bits [31:0] are replaced by the running nonce.
    logic unused_nonce_field;
    assign unused_nonce_field = ^header[31:0];

    assign block0     = hdr_q[639:128];
    assign block1     = {hdr_q[127:32], nonce_q, 1'b1, 319'b0, 64'd640};
    assign hit        = core_hash < target_q;
    assign last_nonce = nonce_q == nonce_end_q;
    assign accept     = (state_q == StIdle) && start && !abort;

`ifdef UPCOIN_DOUBLE_HASH_EN
    logic [255:0] digest1_q;
    logic [511:0] block2;
    assign block2 = {digest1_q, 1'b1, 191'b0, 64'd256};
`endif

    assign found        = found_q;
    assign exhausted    = exhausted_q;
    assign result_nonce = result_nonce_q;
    assign result_hash  = result_hash_q;

    // FSM state and compression cycle counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and core handshake outputs; abort overrides every transition.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        busy              = (state_q != StIdle);
        core_message_load = 1'b1;
        core_block_load   = 1'b1;
        core_block        = '0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                core_block = block0;
                state_d    = StKick0;
            end
            StKick0: begin
                core_block      = block0;
                core_block_load = 1'b0;
                cnt_d           = '0;
                state_d         = StRun0;
            end
            StRun0: begin
                core_block = block0;
                if (cnt_q == CntLast) state_d = StKick1;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            StKick1: begin
                core_block      = block1;
                core_block_load = 1'b0;
                cnt_d           = '0;
                state_d         = StRun1;
            end
            StRun1: begin
                core_block = block1;
                if (cnt_q == CntLast) state_d = StFinish;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            StFinish: begin
                // Dropping message_load lets the core finish and raise done.
                core_block        = block1;
                core_message_load = 1'b0;
`ifdef UPCOIN_DOUBLE_HASH_EN
                if (core_done) state_d = StLoad2;
`else
                if (core_done) state_d = StCheck;
`endif
            end
`ifdef UPCOIN_DOUBLE_HASH_EN
            StLoad2: begin
                core_block = block2;
                state_d    = StKick2;
            end
            StKick2: begin
                core_block      = block2;
                core_block_load = 1'b0;
                cnt_d           = '0;
                state_d         = StRun2;
            end
            StRun2: begin
                core_block = block2;
                if (cnt_q == CntLast) state_d = StFinish2;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            StFinish2: begin
                core_block        = block2;
                core_message_load = 1'b0;
                if (core_done) state_d = StCheck;
            end
`endif
            StCheck: begin
                if (hit || last_nonce) state_d = StIdle;
                else                   state_d = StLoad;
            end
            default: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    // Search context, sticky flags and per-nonce results.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hdr_q          <= '0;
            target_q       <= '0;
            nonce_q        <= '0;
            nonce_end_q    <= '0;
            found_q        <= 1'b0;
            exhausted_q    <= 1'b0;
            result_nonce_q <= '0;
            result_hash_q  <= '0;
`ifdef UPCOIN_DOUBLE_HASH_EN
            digest1_q      <= '0;
`endif
        end else begin
            if (accept) begin
                hdr_q       <= header[639:32];
                target_q    <= target;
                nonce_q     <= nonce_start;
                nonce_end_q <= nonce_end;
                found_q     <= 1'b0;
                exhausted_q <= 1'b0;
            end
`ifdef UPCOIN_DOUBLE_HASH_EN
            if (state_q == StFinish && core_done) digest1_q <= core_hash;
`endif
            // An abort in CHECK discards this nonce's outcome entirely.
            if (state_q == StCheck && !abort) begin
                result_nonce_q <= nonce_q;
                result_hash_q  <= core_hash;
                if (hit)             found_q     <= 1'b1;
                else if (last_nonce) exhausted_q <= 1'b1;
                else                 nonce_q     <= nonce_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_upcoin_nonce_scheduler.sv
// Bench for upcoin_nonce_scheduler: a stand-in core with a cheap block-mixing digest, a
// cycle-offset model of the search loop checked every cycle, and directed scenarios with
// hand-computed results.
module tb_upcoin_nonce_scheduler;

    localparam int unsigned B = 68;
    localparam int Bi = B;
`ifdef UPCOIN_DOUBLE_HASH_EN
    localparam int NonceCyc = 3 * Bi + 10;
`else
    localparam int NonceCyc = 2 * Bi + 6;
`endif

    logic         clk = 1'b0;
    logic         reset_n, start, abort;
    logic [639:0] header;
    logic [255:0] target;
    logic [31:0]  nonce_start, nonce_end;
    logic         busy, found, exhausted;
    logic [31:0]  result_nonce;
    logic [255:0] result_hash;
    logic         core_message_load, core_block_load;
    logic [511:0] core_block;
    logic         core_done;
    logic [255:0] core_hash;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    upcoin_nonce_scheduler #(.BLOCK_CYCLES(B)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .abort             (abort),
        .header            (header),
        .target            (target),
        .nonce_start       (nonce_start),
        .nonce_end         (nonce_end),
        .busy              (busy),
        .found             (found),
        .exhausted         (exhausted),
        .result_nonce      (result_nonce),
        .result_hash       (result_hash),
        .core_message_load (core_message_load),
        .core_block_load   (core_block_load),
        .core_block        (core_block),
        .core_done         (core_done),
        .core_hash         (core_hash)
    );

    always #5 clk = ~clk;

    // Free-running edge counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] mix(input logic [255:0] a, input logic [511:0] blk);
        return {a[254:0], a[255]} ^ blk[511:256] ^ blk[255:0];
    endfunction

    function automatic logic [511:0] blk0(input logic [639:0] h);
        return h[639:128];
    endfunction

    function automatic logic [511:0] blk1(input logic [639:0] h, input logic [31:0] n);
        return {h[127:32], n, 1'b1, 319'b0, 64'd640};
    endfunction

    function automatic logic [511:0] blk2(input logic [255:0] d);
        return {d, 1'b1, 191'b0, 64'd256};
    endfunction

    function automatic logic [255:0] first_digest(input logic [639:0] h, input logic [31:0] n);
        return mix(mix(256'd0, blk0(h)), blk1(h, n));
    endfunction

    function automatic logic [255:0] final_digest(input logic [639:0] h, input logic [31:0] n);
`ifdef UPCOIN_DOUBLE_HASH_EN
        return mix(256'd0, blk2(first_digest(h, n)));
`else
        return first_digest(h, n);
`endif
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Stand-in core: mixes each block presented on a block_load low pulse, raises done one
    // cycle after message_load drops, and restarts its digest after done or while idle.
    logic [255:0] acc;
    always @(posedge clk) begin
        if (!reset_n || !busy)   acc <= '0;
        else if (!core_block_load) acc <= mix(acc, core_block);
        else if (core_done)      acc <= '0;
        if (!reset_n) begin
            core_done <= 1'b0;
            core_hash <= '0;
        end else begin
            core_done <= !core_message_load && !core_done;
            if (!core_message_load && !core_done) core_hash <= acc;
        end
    end

    // Model: progress within the current nonce counted as a cycle offset from LOAD.
    logic         m_active = 1'b0;
    int           m_off = 0;
    logic [639:0] m_hdr = '0;
    logic [255:0] m_target = '0;
    logic [31:0]  m_nonce = '0, m_end = '0;
    logic         m_found = 1'b0, m_exh = 1'b0;
    logic [31:0]  m_rn = '0;
    logic [255:0] m_rh = '0;
    logic [31:0]  m_tried[$];

    // Compare DUT outputs with the model each negedge, then advance the model over the
    // coming posedge using the inputs it will sample.
    initial begin : compare
        logic         kick, fin, blk_chk;
        logic [511:0] eb;
        logic [255:0] d;
        forever begin
            @(negedge clk);
            kick = 1'b0; fin = 1'b0; blk_chk = 1'b0; eb = '0;
            if (m_active) begin
                if (m_off == 0 || m_off == 1) begin
                    blk_chk = 1'b1; eb = blk0(m_hdr); kick = (m_off == 1);
                end
                if (m_off == Bi + 2) begin
                    blk_chk = 1'b1; eb = blk1(m_hdr, m_nonce); kick = 1'b1;
                end
                if (m_off == 2 * Bi + 3 || m_off == 2 * Bi + 4) fin = 1'b1;
`ifdef UPCOIN_DOUBLE_HASH_EN
                if (m_off == 2 * Bi + 5 || m_off == 2 * Bi + 6) begin
                    blk_chk = 1'b1; eb = blk2(first_digest(m_hdr, m_nonce));
                    kick = (m_off == 2 * Bi + 6);
                end
                if (m_off == 3 * Bi + 7 || m_off == 3 * Bi + 8) fin = 1'b1;
`endif
            end
            chk("busy", busy, m_active);
            chk("found", found, m_found);
            chk("exhausted", exhausted, m_exh);
            chk("result_nonce", result_nonce, m_rn);
            chk("result_hash", result_hash, m_rh);
            chk("core_message_load", core_message_load, !fin);
            chk("core_block_load", core_block_load, !kick);
            if (blk_chk) chk("core_block", core_block, eb);

            if (!reset_n) begin
                m_active = 1'b0; m_found = 1'b0; m_exh = 1'b0; m_rn = '0; m_rh = '0;
            end else if (m_active) begin
                if (abort) begin
                    m_active = 1'b0;
                end else if (m_off == NonceCyc - 1) begin
                    d = final_digest(m_hdr, m_nonce);
                    m_tried.push_back(m_nonce);
                    m_rn = m_nonce;
                    m_rh = d;
                    if (d < m_target) begin
                        m_found = 1'b1; m_active = 1'b0;
                    end else if (m_nonce == m_end) begin
                        m_exh = 1'b1; m_active = 1'b0;
                    end else begin
                        m_nonce = m_nonce + 32'd1; m_off = 0;
                    end
                end else begin
                    m_off++;
                end
            end else if (start && !abort) begin
                m_active = 1'b1; m_off = 0; m_found = 1'b0; m_exh = 1'b0;
                m_hdr = header; m_target = target; m_nonce = nonce_start; m_end = nonce_end;
                m_tried.delete();
            end
        end
    end

    task automatic launch(input logic [639:0] h, input logic [255:0] t,
                          input logic [31:0] ns, input logic [31:0] ne, output int t0);
        @(posedge clk); #1;
        header = h; target = t; nonce_start = ns; nonce_end = ne; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < limit) begin
            n++;
            @(negedge clk);
        end
        if (busy) chk("wait_idle_timeout", 1'b1, 1'b0);
    endtask

    localparam logic [255:0] Ones = '1;
`ifdef UPCOIN_DOUBLE_HASH_EN
    localparam logic [255:0] Hash5 =
        {96'h800000000000000000000000, 32'h5, 128'h80000000000000000000000000000380};
`else
    localparam logic [255:0] Hash5 =
        {96'h0, 32'h5, 128'h80000000000000000000000000000280};
`endif

    initial begin : stim
        int t0;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        header = '0; target = '0; nonce_start = '0; nonce_end = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single nonce, always hits.
        launch('0, Ones, 32'h5, 32'h5, t0);
        wait_idle(4 * NonceCyc);
        chk("t1_found", found, 1'b1);
        chk("t1_result_nonce", result_nonce, 32'h5);
        chk("t1_result_hash", result_hash, Hash5);
        chk("t1_latency", cyc - t0, NonceCyc);

        // Never hits; inputs changed and start re-pulsed mid-search must be ignored.
        launch('0, '0, 32'h0, 32'h3, t0);
        repeat (10) @(posedge clk);
        #1;
        nonce_start = 32'd99; target = Ones; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(6 * NonceCyc);
        chk("t2_exhausted", exhausted, 1'b1);
        chk("t2_found", found, 1'b0);
        chk("t2_result_nonce", result_nonce, 32'h3);
        chk("t2_latency", cyc - t0, 4 * NonceCyc);

        // Reset during RUN1 returns everything to reset values at the next edge.
        launch('0, Ones, 32'h5, 32'h5, t0);
        repeat (100) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_found", found, 1'b0);
        chk("rst_exhausted", exhausted, 1'b0);
        chk("rst_result_nonce", result_nonce, 32'h0);
        chk("rst_result_hash", result_hash, 256'h0);
        chk("rst_core_block", core_block, 512'h0);
        chk("rst_core_message_load", core_message_load, 1'b1);
        chk("rst_core_block_load", core_block_load, 1'b1);
        reset_n = 1'b1;

        // Fresh start after reset reproduces the single-nonce hit.
        launch('0, Ones, 32'h5, 32'h5, t0);
        wait_idle(4 * NonceCyc);
        chk("t1b_found", found, 1'b1);
        chk("t1b_result_hash", result_hash, Hash5);

        // Wrapping range through 0xFFFFFFFF.
        launch('0, '0, 32'hFFFF_FFFE, 32'h1, t0);
        wait_idle(6 * NonceCyc);
        chk("t3_exhausted", exhausted, 1'b1);
        chk("t3_result_nonce", result_nonce, 32'h1);
        chk("t3_latency", cyc - t0, 4 * NonceCyc);
        chk("t3_model_count", m_tried.size(), 4);
        if (m_tried.size() == 4) begin
            chk("t3_model_order0", m_tried[0], 32'hFFFF_FFFE);
            chk("t3_model_order1", m_tried[1], 32'hFFFF_FFFF);
            chk("t3_model_order2", m_tried[2], 32'h0);
            chk("t3_model_order3", m_tried[3], 32'h1);
        end

        // Threshold hit on the second nonce, just after the wrap.
        launch('0, {96'h0, 32'd2, 128'h0}, 32'hFFFF_FFFF, 32'h10, t0);
        wait_idle(20 * NonceCyc);
`ifndef UPCOIN_DOUBLE_HASH_EN
        chk("t4_found", found, 1'b1);
        chk("t4_result_nonce", result_nonce, 32'h0);
        chk("t4_latency", cyc - t0, 2 * NonceCyc);
`endif

        // Abort in the middle of the second nonce.
        launch('0, '0, 32'h0, 32'h3, t0);
        repeat (NonceCyc + 69) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_found", found, 1'b0);
        chk("abort_exhausted", exhausted, 1'b0);
        chk("abort_core_message_load", core_message_load, 1'b1);
        chk("abort_result_nonce", result_nonce, 32'h0);

        // Start together with abort in IDLE is ignored.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 1'b0);
        repeat (3) @(posedge clk);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

endmodule
